// File: rtl/conv_layer_sequencer.sv
// Layer sequencer for the convolution datapath: drives the index iterator and MAC accumulator, and hands finished windows to the output writer.
// Optional stall-cycle counter is enabled by defining CONV_SEQ_STALL_CNT_EN.
module conv_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_ready,
  input  logic             iter_finish,
  input  logic             iter_en_sum,
  input  logic             iter_en_save,
  input  logic             out_ready,
  output logic             iter_reset,
  output logic             iter_en,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_idx,
  output logic [7:0]       layer_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WRITE,
    S_FLUSH,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_LAYER = 8'(NUM_LAYERS - 1);

  state_t           state, state_next;
  logic             win_open, win_open_next;
  logic [CNT_W-1:0] out_idx_next;
  logic [7:0]       layer_idx_next;
  logic             window_closed;

  assign window_closed = iter_en_save & win_open;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      win_open  <= 1'b0;
      out_idx   <= '0;
      layer_idx <= '0;
    end else begin
      state     <= state_next;
      win_open  <= win_open_next;
      out_idx   <= out_idx_next;
      layer_idx <= layer_idx_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default up front so no path through the case can infer a latch.
    state_next     = state;
    win_open_next  = win_open;
    out_idx_next   = out_idx;
    layer_idx_next = layer_idx;
    iter_reset     = 1'b0;
    iter_en        = 1'b0;
    acc_en         = 1'b0;
    acc_clr        = 1'b0;
    out_valid      = 1'b0;
    done           = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_CLEAR;
          layer_idx_next = '0;
        end
      end

      S_CLEAR: begin
        iter_reset    = 1'b1;
        acc_clr       = 1'b1;
        out_idx_next  = '0;
        win_open_next = 1'b0;
        state_next    = S_RUN;
      end

      S_RUN: begin
        // Holding the iterator on a closed window keeps the next window's first tap out of this sum.
        iter_en = mem_ready & ~window_closed & ~iter_finish;
        acc_en  = iter_en & iter_en_sum;
        if (iter_en && !iter_en_save) win_open_next = 1'b1;
        if (iter_finish)        state_next = S_FLUSH;
        else if (window_closed) state_next = S_WRITE;
      end

      S_WRITE, S_FLUSH: begin
        if (state == S_FLUSH && !win_open) begin
          state_next = S_NEXT;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            acc_clr       = 1'b1;
            win_open_next = 1'b0;
            out_idx_next  = out_idx + CNT_W'(1);
            state_next    = (state == S_WRITE) ? S_RUN : S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (layer_idx == LAST_LAYER) begin
          state_next = S_DONE;
        end else begin
          layer_idx_next = layer_idx + 8'd1;
          state_next     = S_CLEAR;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  logic        stall_inc;
  logic [15:0] stall_q;

  assign stall_inc    = ((state == S_RUN) & ~mem_ready) | (out_valid & ~out_ready);
  assign stall_cycles = stall_q;

  // Accumulates across all layers of a sequence so it can be read once done has pulsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state == S_CLEAR && layer_idx == 8'd0) begin
      stall_q <= '0;
    end else if (stall_inc && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Top-level controller for the convolution datapath. Runs NUM_LAYERS conv layers back to back, one start pulse for the whole sequence. For each layer it resets and enables the index iterator, stalls it on memory back-pressure and gates the MAC accumulator. At every output-window boundary it hands the accumulated pixel to the output writer over a valid/ready handshake.

Parameters:
NUM_LAYERS, 3, number of conv layers sequenced per start (1..255)
CNT_W, 16, width of the per-layer output-window counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins the sequence from IDLE
mem_ready  in  1  input/weight memory data valid this cycle
iter_finish  in  1  iterator finished the current layer
iter_en_sum  in  1  iterator's current tap is in-bounds (accumulate)
iter_en_save  in  1  iterator is at a window boundary
out_ready  in  1  output writer accepts the word
iter_reset  out  1  synchronous reset to the iterator
iter_en  out  1  iterator en_ctrl (advance)
acc_en  out  1  accumulator add enable
acc_clr  out  1  accumulator clear
out_valid  out  1  accumulated pixel available
out_idx  out  CNT_W  window index within the layer, valid with out_valid
layer_idx  out  8  current layer number, 0-based
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at sequence end
stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset: state=IDLE. All outputs 0, including layer_idx, out_idx, win_open and stall_cycles. Reset mid-operation aborts immediately; there is no partial write.
- States: IDLE, CLEAR, RUN, WRITE, FLUSH, NEXT, DONE.
- IDLE:
  - start=1 -> CLEAR, layer_idx=0.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - iter_reset=1, acc_clr=1.
  - out_idx<=0, win_open<=0.
  - -> RUN.
- RUN:
  - iter_en = mem_ready & ~(iter_en_save & win_open) & ~iter_finish.
  - acc_en = iter_en & iter_en_sum.
  - win_open<=1 on any cycle with iter_en=1 and iter_en_save=0.
  - iter_en_save & win_open (window closed) -> WRITE. The iterator is not advanced that cycle, so the first tap of the next window is never summed into the previous one.
  - iter_finish=1 -> FLUSH. iter_finish takes priority over the save condition when both are true.
  - mem_ready=0: hold, iter_en=0, acc_en=0.
- WRITE:
  - out_valid=1; out_idx stable while waiting.
  - On out_valid & out_ready: acc_clr=1, win_open<=0, out_idx<=out_idx+1 (wraps at 2^CNT_W), -> RUN.
  - out_ready may be held low indefinitely; hold state.
- FLUSH: if win_open, behaves as WRITE, then -> NEXT. If not win_open, -> NEXT with no write.
- NEXT (1 cycle):
  - If layer_idx==NUM_LAYERS-1 -> DONE.
  - Otherwise layer_idx<=layer_idx+1 and -> CLEAR.
- DONE (1 cycle): done=1, -> IDLE. layer_idx holds its final value until the next start.
- Latency: start to first iter_en = 2 cycles (CLEAR, then RUN with mem_ready=1). Handshake completion to next iter_en = 1 cycle.
- out_valid never drops before out_ready is seen. acc_clr and acc_en are never high in the same cycle.

Optional Feature:
CONV_SEQ_STALL_CNT_EN:
- Defined: stall_cycles counts cycles in RUN with mem_ready=0, plus cycles in WRITE/FLUSH with out_valid=1 and out_ready=0. The counter saturates at 16'hFFFF, clears in CLEAR of layer 0, and is readable after done.
- Undefined: stall_cycles is tied to 0 and no counter logic exists.

Test Plan:
- NUM_LAYERS=1, iterator model with 4 windows of 2 taps each, mem_ready=1, out_ready=1 -> 4 writes with out_idx 0,1,2,3. done pulses exactly once. Each write value equals the sum of its 2 taps.
- mem_ready low for 5 cycles mid-window -> iter_en=0 and acc_en=0 for those 5 cycles, result unchanged. With CONV_SEQ_STALL_CNT_EN, stall_cycles=5.
- out_ready held low 10 cycles in WRITE -> out_valid stays 1 and out_idx is stable; acc_clr fires on the accept cycle only. With the macro, stall_cycles=10.
- NUM_LAYERS=3 -> layer_idx steps 0,1,2; iter_reset pulses 3 times; out_idx restarts at 0 each layer; busy is high from the cycle after start until done.
- Reset asserted while in WRITE with out_ready=0 -> next cycle all outputs 0 and state IDLE. A start while busy has no effect.
- iter_finish and iter_en_save asserted together with win_open=1 -> one FLUSH write, then NEXT. No duplicate write occurs.
